top_level_design: RTL and testbench

TOP_LEVEL_DESIGN -- requirements
Module: top_level_design

---
 rtl/top_level_design.sv | 245 ++++++++++++++++++++++++
 tb/tb_top_level_design.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/top_level_design.sv
// Minimum-drop two-phone floor search with an eight-digit multiplexed hex display.
// Live drop, k and break counters are scanned out on active-low segment/select lines.
module top_level_design #(
  parameter int SCAN_BITS = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] in_data_i,
  input  logic        is_init_floors_i,
  input  logic        is_init_resistance_i,
  output logic [7:0]  o_seg_o,
  output logic [7:0]  o_sel_o,
  output logic        last_broken_o
);

  typedef enum logic [1:0] {
    ST_CALC_K = 2'd0,
    ST_DROP1  = 2'd1,
    ST_DROP2  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [SCAN_BITS-1:0] SCAN_ONE = SCAN_BITS'(1);
  localparam logic [SCAN_BITS-1:0] SCAN_MAX = {SCAN_BITS{1'b1}};

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  state_t          state_r, state_s;
  logic [15:0]     floors_r, floors_s;
  logic [15:0]     resist_r, resist_s;
  logic [31:0]     k_r, k_s;
  logic [15:0]     drops_r, drops_s;
  logic [1:0]      broken_r, broken_s;
  logic [31:0]     step_r, step_s;
  logic [31:0]     f_r, f_s;
  logic [31:0]     lo_r, lo_s;
  logic [31:0]     hi_r, hi_s;
  logic            last_r, last_s;
  logic [SCAN_BITS-1:0] scan_r;
  logic [2:0]      digit_r;
  logic [7:0]      sel_r;
  logic [7:0]      seg_r;
  logic [3:0]      nibble_s;

  logic [31:0] floors32_s;
  logic [31:0] resist32_s;
  logic [31:0] tri_s;
  logic [31:0] sum_s;
  logic [31:0] f_min_s;
  logic        init_any_s;

  assign floors32_s = {16'd0, floors_r};
  assign resist32_s = {16'd0, resist_r};
  assign tri_s      = (k_r * (k_r + 32'd1)) >> 1;
  assign sum_s      = f_r + step_r;
  assign f_min_s    = (sum_s > floors32_s) ? floors32_s : sum_s;
  assign init_any_s = is_init_floors_i | is_init_resistance_i;

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_s  = state_r;
    floors_s = floors_r;
    resist_s = resist_r;
    k_s      = k_r;
    drops_s  = drops_r;
    broken_s = broken_r;
    step_s   = step_r;
    f_s      = f_r;
    lo_s     = lo_r;
    hi_s     = hi_r;
    last_s   = last_r;
    if (init_any_s) begin
      if (is_init_floors_i) begin
        floors_s = in_data_i;
      end else begin
        floors_s = floors_r;
      end
      if (is_init_resistance_i) begin
        resist_s = in_data_i;
      end else begin
        resist_s = resist_r;
      end
      state_s  = ST_CALC_K;
      k_s      = 32'd0;
      drops_s  = 16'd0;
      broken_s = 2'd0;
      last_s   = 1'b0;
    end else begin
      case (state_r)
        ST_CALC_K: begin
          if (tri_s >= floors32_s) begin
            if (floors32_s == 32'd0) begin
              state_s = ST_DONE;
              last_s  = 1'b0;
            end else begin
              state_s = ST_DROP1;
              step_s  = k_r;
              f_s     = 32'd0;
            end
          end else begin
            k_s = k_r + 32'd1;
          end
        end
        ST_DROP1: begin
          drops_s = drops_r + 16'd1;
          if (f_min_s > resist32_s) begin
            broken_s = broken_r + 2'd1;
            lo_s     = f_r + 32'd1;
            hi_s     = f_min_s - 32'd1;
            state_s  = ST_DROP2;
          end else if (f_min_s == floors32_s) begin
            state_s = ST_DONE;
            last_s  = 1'b0;
          end else begin
            step_s = (step_r > 32'd1) ? (step_r - 32'd1) : 32'd1;
            f_s    = f_min_s;
          end
        end
        ST_DROP2: begin
          // An empty linear range means the first phone broke one floor above a known survivor.
          if (lo_r > hi_r) begin
            state_s = ST_DONE;
            last_s  = 1'b1;
          end else begin
            drops_s = drops_r + 16'd1;
            if (lo_r > resist32_s) begin
              broken_s = broken_r + 2'd1;
              state_s  = ST_DONE;
              last_s   = 1'b1;
            end else if (lo_r == hi_r) begin
              state_s = ST_DONE;
              last_s  = 1'b0;
            end else begin
              lo_s = lo_r + 32'd1;
            end
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_DONE;
        end
      endcase
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= ST_DONE;
      floors_r <= 16'd0;
      resist_r <= 16'd0;
      k_r      <= 32'd0;
      drops_r  <= 16'd0;
      broken_r <= 2'd0;
      step_r   <= 32'd0;
      f_r      <= 32'd0;
      lo_r     <= 32'd0;
      hi_r     <= 32'd0;
      last_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      floors_r <= floors_s;
      resist_r <= resist_s;
      k_r      <= k_s;
      drops_r  <= drops_s;
      broken_r <= broken_s;
      step_r   <= step_s;
      f_r      <= f_s;
      lo_r     <= lo_s;
      hi_r     <= hi_s;
      last_r   <= last_s;
    end
  end

  // Pick the hex nibble shown on the currently selected digit.
  always_comb begin
    nibble_s = 4'h0;
    case (digit_r)
      3'd0:    nibble_s = {2'b00, broken_r};
      3'd1:    nibble_s = k_r[3:0];
      3'd2:    nibble_s = k_r[7:4];
      3'd3:    nibble_s = k_r[11:8];
      3'd4:    nibble_s = drops_r[3:0];
      3'd5:    nibble_s = drops_r[7:4];
      3'd6:    nibble_s = drops_r[11:8];
      3'd7:    nibble_s = drops_r[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  // Free-running scan counter; its wrap steps the digit index.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      scan_r  <= '0;
      digit_r <= 3'd0;
    end else begin
      scan_r <= scan_r + SCAN_ONE;
      if (scan_r == SCAN_MAX) begin
        digit_r <= digit_r + 3'd1;
      end else begin
        digit_r <= digit_r;
      end
    end
  end

  // Registered display drivers; blanked while in reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_r <= 8'hFF;
      seg_r <= 8'hFF;
    end else begin
      sel_r <= ~(8'd1 << digit_r);
      seg_r <= hex_to_seg(nibble_s);
    end
  end

  assign o_sel_o       = sel_r;
  assign o_seg_o       = seg_r;
  assign last_broken_o = last_r;

endmodule

// File: tb/tb_top_level_design.sv
// Randomized bench for top_level_design: results are read back through the
// scanned display and compared with a floor-by-floor model of the drop rules.
module tb_top_level_design;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] in_data_i = 16'd0;
  logic        is_init_floors_i = 1'b0;
  logic        is_init_resistance_i = 1'b0;
  logic [7:0]  o_seg_o;
  logic [7:0]  o_sel_o;
  logic        last_broken_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  top_level_design #(.SCAN_BITS(2)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .in_data_i            (in_data_i),
    .is_init_floors_i     (is_init_floors_i),
    .is_init_resistance_i (is_init_resistance_i),
    .o_seg_o              (o_seg_o),
    .o_sel_o              (o_sel_o),
    .last_broken_o        (last_broken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drop the phone floor by floor following the two-phase rules.
  task automatic model(input int n, input int r, output int k, output int dr, output int br, output int lst);
    int step;
    int f;
    int prev;
    k = 0;
    while (k * (k + 1) / 2 < n) k++;
    dr = 0; br = 0; lst = 0;
    if (n == 0) return;
    step = k;
    f = 0;
    forever begin
      prev = f;
      f = (f + step > n) ? n : f + step;
      dr++;
      if (f > r) begin
        br++;
        lst = 1;
        for (int g = prev + 1; g <= f - 1; g++) begin
          dr++;
          if (g > r) begin
            br++;
            return;
          end else if (g == f - 1) begin
            lst = 0;
            return;
          end
        end
        return;
      end else if (f == n) begin
        return;
      end else begin
        step = (step > 1) ? step - 1 : 1;
      end
    end
  endtask

  task automatic do_init(input logic floors, input logic [15:0] val);
    @(negedge clk_i);
    in_data_i = val;
    is_init_floors_i = floors;
    is_init_resistance_i = ~floors;
    @(negedge clk_i);
    is_init_floors_i = 1'b0;
    is_init_resistance_i = 1'b0;
  endtask

  // Watch a full scan and rebuild the 8-digit hex word from segment codes.
  task automatic read_display(output logic [31:0] word, output logic ok);
    logic [7:0] seen;
    int idx;
    int nib;
    seen = 8'h00;
    ok = 1'b1;
    word = 32'd0;
    repeat (40) begin
      @(negedge clk_i);
      idx = -1;
      for (int i = 0; i < 8; i++) if (o_sel_o == ~(8'd1 << i)) idx = i;
      if (idx < 0) begin
        ok = 1'b0;
      end else begin
        nib = -1;
        for (int j = 0; j < 16; j++) if (o_seg_o == seg_tab[j]) nib = j;
        if (nib < 0) ok = 1'b0;
        else word[idx*4 +: 4] = nib[3:0];
        seen[idx] = 1'b1;
      end
    end
    if (seen != 8'hFF) ok = 1'b0;
  endtask

  // Wait the allowed latency after the last restart, then check results.
  task automatic finish_case(input string name, input int n, input int r, output logic [31:0] word);
    int k, dr, br, lst;
    logic ok;
    logic [31:0] exp_word;
    model(n, r, k, dr, br, lst);
    check_eq({name, "_last_busy"}, {31'd0, last_broken_o}, 32'd0);
    repeat (k + dr + 4) @(negedge clk_i);
    check_eq({name, "_last"}, {31'd0, last_broken_o}, lst);
    read_display(word, ok);
    exp_word = {dr[15:0], k[11:0], br[3:0]};
    check_eq({name, "_disp_ok"}, {31'd0, ok}, 32'd1);
    check_eq({name, "_disp"}, word, exp_word);
    check_eq({name, "_last_hold"}, {31'd0, last_broken_o}, lst);
  endtask

  task automatic run_case(input string name, input int n, input int r, output logic [31:0] word);
    do_init(1'b1, n[15:0]);
    do_init(1'b0, r[15:0]);
    finish_case(name, n, r, word);
  endtask

  initial begin
    logic [31:0] word;
    logic ok;
    int nf, rr;

    #12;
    check_eq("rst_sel", {24'd0, o_sel_o}, 32'hFF);
    check_eq("rst_seg", {24'd0, o_seg_o}, 32'hFF);
    check_eq("rst_last", {31'd0, last_broken_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk_i);
      check_eq($sformatf("scan_sel_%0d", n), {24'd0, o_sel_o}, {24'd0, ~(8'd1 << (((n - 1) / 4) % 8))});
      check_eq($sformatf("scan_seg_%0d", n), {24'd0, o_seg_o}, 32'hC0);
    end

    run_case("n30_r19", 30, 19, word);
    check_eq("n30_r19_const", word, 32'h00080082);
    check_eq("n30_r19_last_const", {31'd0, last_broken_o}, 32'd1);
    run_case("n30_r40", 30, 40, word);
    run_case("n30_r0", 30, 0, word);
    run_case("n10_r9", 10, 9, word);
    run_case("n10_r20", 10, 20, word);
    run_case("n0_r5", 0, 5, word);
    run_case("n1_r0", 1, 0, word);
    run_case("nmax", 65535, 40000, word);

    for (int i = 0; i < 10; i++) begin
      nf = $urandom_range(0, 300);
      rr = $urandom_range(0, 320);
      run_case($sformatf("rnd%0d", i), nf, rr, word);
    end

    do_init(1'b1, 16'd30);
    do_init(1'b0, 16'd19);
    repeat (5) @(negedge clk_i);
    check_eq("restart_busy", {31'd0, last_broken_o}, 32'd0);
    do_init(1'b0, 16'd5);
    finish_case("restart_r5", 30, 5, word);

    do_init(1'b1, 16'd30);
    do_init(1'b0, 16'd19);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_eq("midrst_sel", {24'd0, o_sel_o}, 32'hFF);
    check_eq("midrst_seg", {24'd0, o_seg_o}, 32'hFF);
    check_eq("midrst_last", {31'd0, last_broken_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (60) @(negedge clk_i);
    read_display(word, ok);
    check_eq("postrst_disp_ok", {31'd0, ok}, 32'd1);
    check_eq("postrst_disp", word, 32'd0);
    check_eq("postrst_last", {31'd0, last_broken_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
